mem_master: RTL and testbench

MEM_MASTER -- requirements
Module: mem_master

---
 rtl/mem_master.sv | 197 +++++++++++++++++++
 tb/tb_mem_master.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_master.sv
// mem_master: bridges a 32-bit CPU load/store/fetch port onto a byte-wide,
// combinational-read memory of 96 bytes. Multi-byte accesses are moved one
// byte per cycle, big-endian, with alignment and range checks done up front.
module mem_master (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sx,
  input  logic        iord,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        m_r,
  output logic        m_w,
  output logic [6:0]  m_addr,
  output logic [7:0]  m_wdata,
  input  logic [7:0]  m_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    XFER = 2'b01,
    DONE = 2'b10,
    ERR  = 2'b11
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;

  // Highest valid byte index in the memory window.
  localparam logic [33:0] LAST_BYTE = 34'd95;

  state_t state_q, state_d;

  // Access context captured at acceptance.
  logic [6:0]  base_q;
  logic [1:0]  last_q;   // index of the final byte, n-1
  logic [1:0]  k_q;      // byte counter inside XFER
  logic [1:0]  size_q;
  logic        sx_q;
  logic        load_q;
  logic [31:0] wdata_q;
  logic [23:0] acc_q;    // bytes already read in this load

  // Decode of the request currently presented on the CPU side.
  logic        req_load;
  logic [1:0]  req_size;
  logic [2:0]  req_n;
  logic [1:0]  req_last;
  logic [33:0] req_base;
  logic [33:0] req_end;
  logic        req_bad;

  // Load word assembled from previous bytes plus the byte on the bus now.
  logic [31:0] load_word;
  logic [1:0]  wr_idx;
  logic        accept;

  // Sign or zero extension of a completed load according to its size.
  function automatic logic [31:0] extend(input logic [1:0] sz,
                                         input logic       s,
                                         input logic [31:0] w);
    logic [31:0] r;
    case (sz)
      SZ_BYTE: r = s ? {{24{w[7]}}, w[7:0]}   : {24'd0, w[7:0]};
      SZ_HALF: r = s ? {{16{w[15]}}, w[15:0]} : {16'd0, w[15:0]};
      default: r = w;
    endcase
    return r;
  endfunction

  // Classify the incoming request: effective size, base address, legality.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first so no path leaves it unassigned, which would infer a latch.
    req_load = iord | ~we;
    req_size = iord ? SZ_WORD : size;
    req_n    = 3'd4;
    req_last = 2'd3;
    case (req_size)
      SZ_BYTE: begin req_n = 3'd1; req_last = 2'd0; end
      SZ_HALF: begin req_n = 3'd2; req_last = 2'd1; end
      default: begin req_n = 3'd4; req_last = 2'd3; end
    endcase
    // Fetch addresses are word indices; data addresses are offsets past the
    // 32-byte instruction area. Wide arithmetic keeps huge addresses from
    // wrapping back into range.
    req_base = iord ? {addr, 2'b00} : ({2'b00, addr} + 34'd32);
    req_end  = req_base + {31'd0, req_n} - 34'd1;
    req_bad  = (~iord && size == SZ_BAD)
             | (req_size == SZ_HALF && addr[0])
             | (~iord && req_size == SZ_WORD && addr[1:0] != 2'b00)
             | (req_end > LAST_BYTE)
             | (iord && we);
  end

  assign accept    = (state_q == IDLE) && req;
  assign load_word = {acc_q, m_rdata};
  assign wr_idx    = last_q - k_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and all control outputs.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    m_r     = 1'b0;
    m_w     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) state_d = req_bad ? ERR : XFER;
      end
      XFER: begin
        busy = 1'b1;
        m_r  = load_q;
        m_w  = ~load_q;
        if (k_q == last_q) state_d = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      ERR: begin
        busy    = 1'b1;
        done    = 1'b1;
        err     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory address and store byte for the current step; only meaningful
  // while a strobe is high.
  always_comb begin
    m_addr = base_q + {5'd0, k_q};
    case (wr_idx)
      2'd0:    m_wdata = wdata_q[7:0];
      2'd1:    m_wdata = wdata_q[15:8];
      2'd2:    m_wdata = wdata_q[23:16];
      default: m_wdata = wdata_q[31:24];
    endcase
  end

  // Capture request context at acceptance and step the byte counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q  <= '0;
      last_q  <= '0;
      k_q     <= '0;
      size_q  <= '0;
      sx_q    <= 1'b0;
      load_q  <= 1'b0;
      wdata_q <= '0;
    end else if (accept) begin
      base_q  <= req_base[6:0];
      last_q  <= req_last;
      k_q     <= '0;
      size_q  <= req_size;
      sx_q    <= sx;
      load_q  <= req_load;
      wdata_q <= wdata;
    end else if (state_q == XFER) begin
      k_q <= k_q + 2'd1;
    end
  end

  // Shift read bytes in and publish the extended result on the final byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      rdata <= '0;
    end else if (accept) begin
      acc_q <= '0;
    end else if (state_q == XFER && load_q) begin
      acc_q <= load_word[23:0];
      if (k_q == last_q) rdata <= extend(size_q, sx_q, load_word);
    end
  end

endmodule

// File: tb/tb_mem_master.sv
// tb_mem_master: drives directed and random accesses into mem_master over a
// 96-byte behavioural memory and compares every cycle against a model that
// works from byte arrays and plain address arithmetic.
module tb_mem_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, we, sx, iord;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        busy, done, err, m_r, m_w;
  logic [6:0]  m_addr;
  logic [7:0]  m_wdata, m_rdata;

  logic [7:0]  mem     [96];
  logic [7:0]  ref_mem [96];
  logic [31:0] ref_rdata;

  logic        poke_en;
  logic [6:0]  poke_a;
  logic [7:0]  poke_d;

  int n_vec;
  int n_bad;

  mem_master dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .we      (we),
    .size    (size),
    .sx      (sx),
    .iord    (iord),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .m_r     (m_r),
    .m_w     (m_w),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_rdata (m_rdata)
  );

  always #5 clk = ~clk;

  // Byte-wide memory: combinational read, write on the rising edge.
  assign m_rdata = (m_addr < 7'd96) ? mem[m_addr] : 8'h00;

  always @(posedge clk) begin
    if (m_w && m_addr < 7'd96) mem[m_addr] <= m_wdata;
    if (poke_en) mem[poke_a] <= poke_d;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Write one byte into both the memory and the model (one clock).
  task automatic poke(input int a, input logic [7:0] d);
    poke_en = 1'b1;
    poke_a  = 7'(a);
    poke_d  = d;
    ref_mem[a] = d;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  // Reference rules for accepting an access.
  task automatic model(input bit we_i, input logic [1:0] size_i, input bit iord_i,
                       input logic [31:0] addr_i, output bit bad, output longint base,
                       output int n, output bit load);
    load = iord_i || !we_i;
    if (iord_i) begin
      base = longint'(addr_i) * 4;
      n    = 4;
    end else begin
      base = longint'(addr_i) + 32;
      n    = (size_i == 2'd0) ? 1 : (size_i == 2'd1) ? 2 : 4;
    end
    bad = (iord_i && we_i)
       || (!iord_i && size_i == 2'd3)
       || (!iord_i && size_i == 2'd1 && (addr_i % 2) != 0)
       || (!iord_i && size_i == 2'd2 && (addr_i % 4) != 0)
       || (base + n - 1 > 95);
  endtask

  // One complete access, called and returning on a falling edge. With hold
  // set, req stays high and the other inputs are scrambled while busy.
  task automatic access(input bit we_i, input logic [1:0] size_i, input bit sx_i,
                        input bit iord_i, input logic [31:0] addr_i,
                        input logic [31:0] wdata_i, input bit hold);
    bit          bad, load;
    longint      base;
    int          n;
    logic [31:0] val;
    logic [7:0]  b;
    model(we_i, size_i, iord_i, addr_i, bad, base, n, load);
    req = 1'b1; we = we_i; size = size_i; sx = sx_i; iord = iord_i;
    addr = addr_i; wdata = wdata_i;
    @(posedge clk);
    #1;
    if (hold) begin
      addr = $urandom; wdata = $urandom; size = 2'($urandom); sx = 1'($urandom);
    end else begin
      req = 1'b0;
    end
    if (bad) begin
      @(negedge clk);
      check("err_ctl", {27'd0, busy, done, err, m_r, m_w}, 32'b11100);
      check("err_rdata", rdata, ref_rdata);
    end else begin
      if (load) begin
        val = 32'd0;
        for (int i = 0; i < n; i++) val = (val << 8) | {24'd0, ref_mem[int'(base) + i]};
        if (n == 1 && sx_i && val[7])  val = val | 32'hFFFF_FF00;
        if (n == 2 && sx_i && val[15]) val = val | 32'hFFFF_0000;
      end else begin
        val = ref_rdata;
      end
      for (int k = 0; k < n; k++) begin
        @(negedge clk);
        check("xfer_ctl", {27'd0, busy, done, err, m_r, m_w},
              {27'd0, 3'b100, load, !load});
        check("xfer_addr", {25'd0, m_addr}, 32'(base + k));
        if (!load) begin
          b = 8'(wdata_i >> (8 * (n - 1 - k)));
          check("xfer_wdata", {24'd0, m_wdata}, {24'd0, b});
          ref_mem[int'(base) + k] = b;
        end
      end
      ref_rdata = val;
      @(negedge clk);
      check("done_ctl", {27'd0, busy, done, err, m_r, m_w}, 32'b11000);
      check("done_rdata", rdata, ref_rdata);
      if (!load)
        for (int i = 0; i < n; i++)
          check("store_mem", {24'd0, mem[int'(base) + i]}, {24'd0, ref_mem[int'(base) + i]});
    end
    @(negedge clk);
    check("idle_ctl", {27'd0, busy, done, err, m_r, m_w}, 32'd0);
    check("idle_rdata", rdata, ref_rdata);
  endtask

  initial begin
    n_vec = 0; n_bad = 0;
    rst_n = 1'b0; req = 1'b0; we = 1'b0; size = 2'd0; sx = 1'b0; iord = 1'b0;
    addr = '0; wdata = '0; poke_en = 1'b0; poke_a = '0; poke_d = '0;
    ref_rdata = 32'd0;

    // Reset state.
    #1;
    check("reset_ctl", {27'd0, busy, done, err, m_r, m_w}, 32'd0);
    check("reset_rdata", rdata, 32'd0);

    for (int i = 0; i < 96; i++) poke(i, 8'($urandom));
    rst_n = 1'b1;
    @(negedge clk);

    // Instruction fetch of word index 2.
    poke(8, 8'h12); poke(9, 8'h34); poke(10, 8'h56); poke(11, 8'h78);
    access(1'b0, 2'b00, 1'b0, 1'b1, 32'd2, 32'd0, 1'b0);
    check("fetch_value", rdata, 32'h1234_5678);

    // Word store at data offset 4.
    access(1'b1, 2'b10, 1'b0, 1'b0, 32'd4, 32'hDEAD_BEEF, 1'b0);
    check("store_bytes", {mem[36], mem[37], mem[38], mem[39]}, 32'hDEAD_BEEF);
    check("store_keeps_rdata", rdata, 32'h1234_5678);

    // Byte and half loads with and without sign extension.
    poke(32, 8'h80);
    access(1'b0, 2'b00, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
    check("lb_sx", rdata, 32'hFFFF_FF80);
    access(1'b0, 2'b00, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    check("lb_zx", rdata, 32'h0000_0080);
    poke(34, 8'h80); poke(35, 8'h01);
    access(1'b0, 2'b01, 1'b1, 1'b0, 32'd2, 32'd0, 1'b0);
    check("lh_sx", rdata, 32'hFFFF_8001);

    // Rejected accesses: misaligned half, out-of-range word, fetch with we.
    access(1'b0, 2'b01, 1'b0, 1'b0, 32'd1,  32'd0, 1'b0);
    access(1'b0, 2'b10, 1'b0, 1'b0, 32'd62, 32'd0, 1'b0);
    access(1'b1, 2'b10, 1'b0, 1'b1, 32'd0,  32'd0, 1'b0);
    check("err_keeps_rdata", rdata, 32'hFFFF_8001);

    // Reset in the middle of a word store after two bytes are written.
    req = 1'b1; we = 1'b1; size = 2'b10; sx = 1'b0; iord = 1'b0;
    addr = 32'd4; wdata = 32'hCAFE_F00D;
    @(posedge clk);
    #1 req = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("pre_abort_mw", {31'd0, m_w}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_ctl", {27'd0, busy, done, err, m_r, m_w}, 32'd0);
    check("abort_rdata", rdata, 32'd0);
    ref_rdata = 32'd0;
    ref_mem[36] = 8'hCA;
    ref_mem[37] = 8'hFE;
    check("abort_mem", {mem[36], mem[37], mem[38], mem[39]}, 32'hCAFE_BEEF);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    access(1'b0, 2'b10, 1'b0, 1'b0, 32'd4, 32'd0, 1'b0);
    check("after_abort_load", rdata, 32'hCAFE_BEEF);

    // Back-to-back word loads with req held high throughout.
    access(1'b0, 2'b10, 1'b0, 1'b0, 32'd8,  32'd0, 1'b1);
    access(1'b0, 2'b10, 1'b0, 1'b0, 32'd16, 32'd0, 1'b1);
    access(1'b0, 2'b10, 1'b1, 1'b0, 32'd20, 32'd0, 1'b0);

    // Random mix of loads, stores, fetches, legal and illegal.
    for (int t = 0; t < 150; t++) begin
      bit          r_we, r_sx, r_iord, r_hold;
      logic [1:0]  r_size;
      logic [31:0] r_addr;
      int          gap;
      r_we   = 1'($urandom);
      r_sx   = 1'($urandom);
      r_iord = ($urandom_range(0, 3) == 0);
      r_size = 2'($urandom);
      r_addr = r_iord ? 32'($urandom_range(0, 25)) : 32'($urandom_range(0, 66));
      if ($urandom_range(0, 15) == 0) r_addr = $urandom;
      r_hold = ($urandom_range(0, 3) == 0);
      access(r_we, r_size, r_sx, r_iord, r_addr, $urandom, r_hold);
      gap = $urandom_range(0, 2);
      if (!r_hold) repeat (gap) @(negedge clk);
    end
    req = 1'b0;
    @(negedge clk);

    begin
      int diff;
      diff = 0;
      for (int i = 0; i < 96; i++) if (mem[i] !== ref_mem[i]) diff++;
      check("mem_final", 32'(diff), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
